// File: rtl/sal_cmd_sched_pkg.sv
//------------------------------------------------------------------------------
// Module  : sal_cmd_sched_pkg
// Purpose : Command codes, arbitration class indices and default field widths
//           shared by the DRAM command scheduler.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef DRAM_RA_WIDTH
`define DRAM_RA_WIDTH 16
`endif
`ifndef DRAM_CA_WIDTH
`define DRAM_CA_WIDTH 10
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif

package sal_cmd_sched_pkg;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5
  } cmd_type_e;

  localparam int         c_NUM_CLS = 4;
  localparam logic [1:0] c_CLS_REF = 2'd0;
  localparam logic [1:0] c_CLS_PRE = 2'd1;
  localparam logic [1:0] c_CLS_COL = 2'd2;
  localparam logic [1:0] c_CLS_ACT = 2'd3;

endpackage

`default_nettype wire

// File: rtl/sal_cmd_sched_rr_arb.sv
//------------------------------------------------------------------------------
// Module  : sal_rr_arb
// Purpose : Round-robin arbiter: search starts at i_ptr, returns a one-hot
//           grant, the winning index and the pointer to use after a grant.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module sal_rr_arb #(
  parameter int WIDTH = 4,
  parameter int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [WIDTH-1:0] o_gnt,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_hit,
  output logic [PTR_W-1:0] o_next_ptr
);

  always_comb begin
    int w_k;
    o_gnt = '0;
    o_idx = '0;
    o_hit = 1'b0;
    w_k   = 0;
    for (int i = 0; i < WIDTH; i++) begin
      w_k = (int'(i_ptr) + i) % WIDTH;
      if (!o_hit && i_req[w_k]) begin
        o_hit      = 1'b1;
        o_gnt[w_k] = 1'b1;
        o_idx      = PTR_W'(w_k);
      end
    end
  end

  // Explicit wrap so non-power-of-two widths never leave the legal range
  assign o_next_ptr = (o_idx == PTR_W'(WIDTH - 1)) ? PTR_W'(0) : o_idx + PTR_W'(1);

endmodule

`default_nettype wire

// File: rtl/sal_cmd_sched.sv
//------------------------------------------------------------------------------
// Module  : sal_cmd_sched
// Purpose : Shared DRAM command-bus scheduler, REF > PRE > RD/WR > ACT with
//           per-class round-robin. Optional ACT ageing: SAL_CMD_SCHED_AGE_EN.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module sal_cmd_sched
  import sal_cmd_sched_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int AGE_LIMIT = 63,
  localparam int BA_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [NUM_BANKS-1:0]                         act_req,
  input  logic [NUM_BANKS-1:0]                         rd_req,
  input  logic [NUM_BANKS-1:0]                         wr_req,
  input  logic [NUM_BANKS-1:0]                         pre_req,
  input  logic [NUM_BANKS-1:0]                         ref_req,
  input  logic [NUM_BANKS-1:0][`DRAM_RA_WIDTH-1:0]     req_ra,
  input  logic [NUM_BANKS-1:0][`DRAM_CA_WIDTH-1:0]     req_ca,
  input  logic [NUM_BANKS-1:0][`AXI_ID_WIDTH-1:0]      req_id,
  input  logic [NUM_BANKS-1:0][`AXI_LEN_WIDTH-1:0]     req_len,
  output logic [NUM_BANKS-1:0]                         act_gnt,
  output logic [NUM_BANKS-1:0]                         rd_gnt,
  output logic [NUM_BANKS-1:0]                         wr_gnt,
  output logic [NUM_BANKS-1:0]                         pre_gnt,
  output logic [NUM_BANKS-1:0]                         ref_gnt,
  output logic                                         cmd_valid,
  output cmd_type_e                                    cmd_type,
  output logic [BA_W-1:0]                              cmd_ba,
  output logic [`DRAM_RA_WIDTH-1:0]                    cmd_ra,
  output logic [`DRAM_CA_WIDTH-1:0]                    cmd_ca,
  output logic [`AXI_ID_WIDTH-1:0]                     cmd_id,
  output logic [`AXI_LEN_WIDTH-1:0]                    cmd_len
);

  logic [NUM_BANKS-1:0] w_cls_req [c_NUM_CLS];
  logic [NUM_BANKS-1:0] w_cls_gnt [c_NUM_CLS];
  logic [BA_W-1:0]      w_cls_idx [c_NUM_CLS];
  logic [BA_W-1:0]      w_cls_nxt [c_NUM_CLS];
  logic                 w_cls_hit [c_NUM_CLS];
  logic [BA_W-1:0]      r_ptr     [c_NUM_CLS];

  logic [NUM_BANKS-1:0] w_act_arb_req;
  logic                 w_aged_any;
  logic                 w_grant;
  logic [1:0]           w_sel;
  logic [NUM_BANKS-1:0] w_gnt_vec;
  logic [BA_W-1:0]      w_idx;
  cmd_type_e            w_type;
  logic                 w_is_act;
  logic                 w_is_col;

`ifdef SAL_CMD_SCHED_AGE_EN
  localparam int AGE_W = (AGE_LIMIT > 0) ? $clog2(AGE_LIMIT + 1) : 1;
  logic [NUM_BANKS-1:0] w_aged;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_age
    logic [AGE_W-1:0] r_age;

    assign w_aged[b] = act_req[b] && (r_age >= AGE_W'(AGE_LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_age <= '0;
      end else if (!act_req[b] || act_gnt[b]) begin
        r_age <= '0;
      end else if (r_age < AGE_W'(AGE_LIMIT)) begin
        r_age <= r_age + AGE_W'(1);
      end
    end
  end

  // Aged banks take the ACT arbiter exclusively so the ACT pointer breaks ties
  assign w_aged_any    = |w_aged;
  assign w_act_arb_req = w_aged_any ? w_aged : act_req;
`else
  assign w_aged_any    = 1'b0;
  assign w_act_arb_req = act_req;
`endif

  assign w_cls_req[c_CLS_REF] = ref_req;
  assign w_cls_req[c_CLS_PRE] = pre_req;
  assign w_cls_req[c_CLS_COL] = rd_req | wr_req;
  assign w_cls_req[c_CLS_ACT] = w_act_arb_req;

  for (genvar g = 0; g < c_NUM_CLS; g++) begin : g_cls
    sal_rr_arb #(
      .WIDTH (NUM_BANKS),
      .PTR_W (BA_W)
    ) u_arb (
      .i_req      (w_cls_req[g]),
      .i_ptr      (r_ptr[g]),
      .o_gnt      (w_cls_gnt[g]),
      .o_idx      (w_cls_idx[g]),
      .o_hit      (w_cls_hit[g]),
      .o_next_ptr (w_cls_nxt[g])
    );
  end

  always_comb begin
    w_grant = 1'b0;
    w_sel   = c_CLS_REF;
    if (!rst_n) begin
      w_grant = 1'b0;
    end else if (w_cls_hit[c_CLS_REF]) begin
      w_grant = 1'b1;
      w_sel   = c_CLS_REF;
    end else if (w_aged_any) begin
      w_grant = 1'b1;
      w_sel   = c_CLS_ACT;
    end else if (w_cls_hit[c_CLS_PRE]) begin
      w_grant = 1'b1;
      w_sel   = c_CLS_PRE;
    end else if (w_cls_hit[c_CLS_COL]) begin
      w_grant = 1'b1;
      w_sel   = c_CLS_COL;
    end else if (w_cls_hit[c_CLS_ACT]) begin
      w_grant = 1'b1;
      w_sel   = c_CLS_ACT;
    end
  end

  assign w_gnt_vec = w_grant ? w_cls_gnt[w_sel] : '0;
  assign w_idx     = w_cls_idx[w_sel];

  always_comb begin
    w_type = CMD_NOP;
    if (w_grant) begin
      case (w_sel)
        c_CLS_REF: w_type = CMD_REF;
        c_CLS_PRE: w_type = CMD_PRE;
        c_CLS_COL: w_type = rd_req[w_idx] ? CMD_RD : CMD_WR;
        default:   w_type = CMD_ACT;
      endcase
    end
  end

  assign w_is_act = (w_type == CMD_ACT);
  assign w_is_col = (w_type == CMD_RD) || (w_type == CMD_WR);

  // RD dominates WR when a bank raises both
  assign ref_gnt = (w_sel == c_CLS_REF) ? w_gnt_vec : '0;
  assign pre_gnt = (w_sel == c_CLS_PRE) ? w_gnt_vec : '0;
  assign rd_gnt  = (w_sel == c_CLS_COL) ? (w_gnt_vec & rd_req) : '0;
  assign wr_gnt  = (w_sel == c_CLS_COL) ? (w_gnt_vec & ~rd_req) : '0;
  assign act_gnt = (w_sel == c_CLS_ACT) ? w_gnt_vec : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid <= 1'b0;
      cmd_type  <= CMD_NOP;
      cmd_ba    <= '0;
      cmd_ra    <= '0;
      cmd_ca    <= '0;
      cmd_id    <= '0;
      cmd_len   <= '0;
      for (int c = 0; c < c_NUM_CLS; c++) begin
        r_ptr[c] <= '0;
      end
    end else begin
      cmd_valid <= w_grant;
      cmd_type  <= w_type;
      cmd_ba    <= w_grant  ? w_idx          : '0;
      cmd_ra    <= w_is_act ? req_ra[w_idx]  : '0;
      cmd_ca    <= w_is_col ? req_ca[w_idx]  : '0;
      cmd_id    <= w_is_col ? req_id[w_idx]  : '0;
      cmd_len   <= w_is_col ? req_len[w_idx] : '0;
      if (w_grant) begin
        r_ptr[w_sel] <= w_cls_nxt[w_sel];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sal_cmd_sched.sv
//------------------------------------------------------------------------------
// Module  : tb_sal_cmd_sched
// Purpose : Directed self-checking bench for sal_cmd_sched (AGE_LIMIT=3).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef DRAM_RA_WIDTH
`define DRAM_RA_WIDTH 16
`endif
`ifndef DRAM_CA_WIDTH
`define DRAM_CA_WIDTH 10
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif

module tb_sal_cmd_sched;
  import sal_cmd_sched_pkg::*;

  localparam int NB   = 4;
  localparam int RAW  = `DRAM_RA_WIDTH;
  localparam int CAW  = `DRAM_CA_WIDTH;
  localparam int IDW  = `AXI_ID_WIDTH;
  localparam int LENW = `AXI_LEN_WIDTH;
  localparam int CW   = 1 + 3 + 2 + RAW + CAW + IDW + LENW;
`ifdef SAL_CMD_SCHED_AGE_EN
  localparam bit AGE_EN = 1'b1;
`else
  localparam bit AGE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NB-1:0] act_req, rd_req, wr_req, pre_req, ref_req;
  logic [NB-1:0][RAW-1:0]  req_ra;
  logic [NB-1:0][CAW-1:0]  req_ca;
  logic [NB-1:0][IDW-1:0]  req_id;
  logic [NB-1:0][LENW-1:0] req_len;
  logic [NB-1:0] act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
  logic            cmd_valid;
  cmd_type_e       cmd_type;
  logic [1:0]      cmd_ba;
  logic [RAW-1:0]  cmd_ra;
  logic [CAW-1:0]  cmd_ca;
  logic [IDW-1:0]  cmd_id;
  logic [LENW-1:0] cmd_len;

  int checks = 0;
  int errors = 0;

  wire [19:0]   gnt_all = {ref_gnt, pre_gnt, rd_gnt, wr_gnt, act_gnt};
  wire [CW-1:0] cmd_all = {cmd_valid, cmd_type, cmd_ba, cmd_ra, cmd_ca, cmd_id, cmd_len};

  sal_cmd_sched #(.NUM_BANKS(NB), .AGE_LIMIT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .act_req(act_req), .rd_req(rd_req), .wr_req(wr_req), .pre_req(pre_req), .ref_req(ref_req),
    .req_ra(req_ra), .req_ca(req_ca), .req_id(req_id), .req_len(req_len),
    .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .pre_gnt(pre_gnt), .ref_gnt(ref_gnt),
    .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_ba(cmd_ba), .cmd_ra(cmd_ra),
    .cmd_ca(cmd_ca), .cmd_id(cmd_id), .cmd_len(cmd_len)
  );

  always #5 clk = ~clk;

  // Grant image {ref,pre,rd,wr,act} with a single bit for (type, bank)
  function automatic logic [19:0] gexp(input cmd_type_e t, input int b);
    logic [19:0] v;
    v = '0;
    case (t)
      CMD_REF: v[16+b] = 1'b1;
      CMD_PRE: v[12+b] = 1'b1;
      CMD_RD:  v[8+b]  = 1'b1;
      CMD_WR:  v[4+b]  = 1'b1;
      CMD_ACT: v[b]    = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

  // Expected command bus; bank fields are ra=0x1000+b, ca=0x20+b, id=4+b, len=0x10+b
  function automatic logic [CW-1:0] cexp(input cmd_type_e t, input int b);
    logic [RAW-1:0]  ra;
    logic [CAW-1:0]  ca;
    logic [IDW-1:0]  id;
    logic [LENW-1:0] len;
    ra = '0; ca = '0; id = '0; len = '0;
    if (t == CMD_NOP) return '0;
    if (t == CMD_ACT) ra = RAW'(32'h1000 + b);
    if (t == CMD_RD || t == CMD_WR) begin
      ca  = CAW'(32'h20 + b);
      id  = IDW'(4 + b);
      len = LENW'(32'h10 + b);
    end
    return {1'b1, t, 2'(b), ra, ca, id, len};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = '0;
  endtask

  task automatic test_reset();
    act_req = '1; ref_req = '1;
    #1;
    checks++; if (gnt_all !== 20'h0) begin errors++; $display("FAIL reset_gnt got %h exp %h", gnt_all, 20'h0); end
    checks++; if (cmd_all !== '0) begin errors++; $display("FAIL reset_cmd got %h exp 0", cmd_all); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cmd_all !== '0) begin errors++; $display("FAIL reset_cmd_held got %h exp 0", cmd_all); end
    clear_reqs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (cmd_all !== '0) begin errors++; $display("FAIL reset_idle_cmd got %h exp 0", cmd_all); end
  endtask

  task automatic test_act_rr();
    act_req = 4'b0101;
    #1;
    checks++; if (gnt_all !== gexp(CMD_ACT, 0)) begin errors++; $display("FAIL act_gnt0 got %h exp %h", gnt_all, gexp(CMD_ACT, 0)); end
    tick();
    act_req = 4'b0100;
    #1;
    checks++; if (cmd_all !== cexp(CMD_ACT, 0)) begin errors++; $display("FAIL act_cmd0 got %h exp %h", cmd_all, cexp(CMD_ACT, 0)); end
    checks++; if (gnt_all !== gexp(CMD_ACT, 2)) begin errors++; $display("FAIL act_gnt2 got %h exp %h", gnt_all, gexp(CMD_ACT, 2)); end
    tick();
    act_req = '0;
    #1;
    checks++; if (cmd_all !== cexp(CMD_ACT, 2)) begin errors++; $display("FAIL act_cmd2 got %h exp %h", cmd_all, cexp(CMD_ACT, 2)); end
    tick();
    checks++; if (cmd_all !== '0) begin errors++; $display("FAIL act_nop got %h exp 0", cmd_all); end
  endtask

  task automatic test_ref_over_rd();
    ref_req = 4'b0010; rd_req = 4'b1000;
    #1;
    checks++; if (gnt_all !== gexp(CMD_REF, 1)) begin errors++; $display("FAIL ref_gnt got %h exp %h", gnt_all, gexp(CMD_REF, 1)); end
    tick();
    ref_req = '0;
    #1;
    checks++; if (cmd_all !== cexp(CMD_REF, 1)) begin errors++; $display("FAIL ref_cmd got %h exp %h", cmd_all, cexp(CMD_REF, 1)); end
    checks++; if (gnt_all !== gexp(CMD_RD, 3)) begin errors++; $display("FAIL rd3_gnt got %h exp %h", gnt_all, gexp(CMD_RD, 3)); end
    tick();
    rd_req = '0;
    #1;
    checks++; if (cmd_all !== cexp(CMD_RD, 3)) begin errors++; $display("FAIL rd3_cmd got %h exp %h", cmd_all, cexp(CMD_RD, 3)); end
    checks++; if (gnt_all !== 20'h0) begin errors++; $display("FAIL rd3_idle got %h exp 0", gnt_all); end
  endtask

  task automatic test_back_to_back();
    tick();
    wr_req = '1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (gnt_all !== gexp(CMD_WR, i % 4)) begin errors++; $display("FAIL wr_rot_gnt[%0d] got %h exp %h", i, gnt_all, gexp(CMD_WR, i % 4)); end
      tick();
      if (i == 7) wr_req = '0;
      #1;
      checks++; if (cmd_all !== cexp(CMD_WR, i % 4)) begin errors++; $display("FAIL wr_rot_cmd[%0d] got %h exp %h", i, cmd_all, cexp(CMD_WR, i % 4)); end
    end
  endtask

  task automatic test_rd_wins();
    tick();
    rd_req = 4'b0010; wr_req = 4'b0010;
    #1;
    checks++; if (gnt_all !== gexp(CMD_RD, 1)) begin errors++; $display("FAIL rdwr_gnt got %h exp %h", gnt_all, gexp(CMD_RD, 1)); end
    tick();
    clear_reqs();
    #1;
    checks++; if (cmd_all !== cexp(CMD_RD, 1)) begin errors++; $display("FAIL rdwr_cmd got %h exp %h", cmd_all, cexp(CMD_RD, 1)); end
  endtask

  task automatic test_withdraw();
    tick();
    pre_req = 4'b0001; rd_req = 4'b0100;
    #1;
    checks++; if (gnt_all !== gexp(CMD_PRE, 0)) begin errors++; $display("FAIL wd_pre_gnt got %h exp %h", gnt_all, gexp(CMD_PRE, 0)); end
    tick();
    clear_reqs();
    #1;
    checks++; if (cmd_all !== cexp(CMD_PRE, 0)) begin errors++; $display("FAIL wd_pre_cmd got %h exp %h", cmd_all, cexp(CMD_PRE, 0)); end
    checks++; if (gnt_all !== 20'h0) begin errors++; $display("FAIL wd_no_rd got %h exp 0", gnt_all); end
    tick();
    checks++; if (cmd_all !== '0) begin errors++; $display("FAIL wd_no_rd_cmd got %h exp 0", cmd_all); end
    rd_req = 4'b0100;
    #1;
    rd_req = '0;
    #1;
    checks++; if (gnt_all !== 20'h0) begin errors++; $display("FAIL wd_pulse_gnt got %h exp 0", gnt_all); end
    tick();
    checks++; if (cmd_all !== '0) begin errors++; $display("FAIL wd_pulse_cmd got %h exp 0", cmd_all); end
  endtask

  task automatic test_col_over_act();
    logic [19:0] e;
    act_req = 4'b0001; rd_req = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      e = (AGE_EN && i == 3) ? gexp(CMD_ACT, 0) : gexp(CMD_RD, 1);
      #1;
      checks++; if (gnt_all !== e) begin errors++; $display("FAIL age_gnt[%0d] got %h exp %h", i, gnt_all, e); end
      tick();
      if (AGE_EN && i == 3) act_req = '0;
    end
    clear_reqs();
    tick();
  endtask

  task automatic test_reset_midop();
    pre_req = 4'b0010;
    #1;
    checks++; if (gnt_all !== gexp(CMD_PRE, 1)) begin errors++; $display("FAIL mid_pre_gnt got %h exp %h", gnt_all, gexp(CMD_PRE, 1)); end
    tick();
    pre_req = '0;
    #1;
    checks++; if (cmd_all !== cexp(CMD_PRE, 1)) begin errors++; $display("FAIL mid_pre_cmd got %h exp %h", cmd_all, cexp(CMD_PRE, 1)); end
    rst_n = 1'b0;
    pre_req = 4'b0101;
    #1;
    checks++; if (cmd_all !== '0) begin errors++; $display("FAIL mid_rst_cmd got %h exp 0", cmd_all); end
    checks++; if (gnt_all !== 20'h0) begin errors++; $display("FAIL mid_rst_gnt got %h exp 0", gnt_all); end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (gnt_all !== gexp(CMD_PRE, 0)) begin errors++; $display("FAIL mid_ptr0_gnt got %h exp %h", gnt_all, gexp(CMD_PRE, 0)); end
    checks++; if (cmd_all !== '0) begin errors++; $display("FAIL mid_early_cmd got %h exp 0", cmd_all); end
    tick();
    pre_req = '0;
    #1;
    checks++; if (cmd_all !== cexp(CMD_PRE, 0)) begin errors++; $display("FAIL mid_first_cmd got %h exp %h", cmd_all, cexp(CMD_PRE, 0)); end
  endtask

  task automatic test_idle();
    tick();
    checks++; if (gnt_all !== 20'h0) begin errors++; $display("FAIL idle_gnt got %h exp 0", gnt_all); end
    checks++; if (cmd_all !== '0) begin errors++; $display("FAIL idle_cmd got %h exp 0", cmd_all); end
  endtask

  initial begin
    clear_reqs();
    for (int b = 0; b < NB; b++) begin
      req_ra[b]  = RAW'(32'h1000 + b);
      req_ca[b]  = CAW'(32'h20 + b);
      req_id[b]  = IDW'(4 + b);
      req_len[b] = LENW'(32'h10 + b);
    end
    test_reset();
    test_act_rr();
    test_ref_over_rd();
    test_back_to_back();
    test_rd_wins();
    test_withdraw();
    test_col_over_act();
    test_reset_midop();
    test_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
